// File: rtl/threshold_adj_mc.sv
// Multi-channel key-driven threshold adjuster with per-channel grades and auto-repeat.
// Optional build macro THRESH_WRAP_EN: up/down steps wrap instead of saturating.
module threshold_adj_mc #(
  parameter int unsigned CH         = 4,
  parameter int unsigned GRADES     = 16,
  parameter int unsigned GRADE_INIT = 9,
  parameter int unsigned TW         = 8,
  parameter int unsigned THR_BASE   = 10,
  parameter int unsigned THR_STEP   = 10,
  parameter int unsigned REP_DLY    = 50000000,
  parameter int unsigned REP_PER    = 10000000,
  localparam int unsigned CSW       = (CH > 1) ? $clog2(CH) : 1,
  localparam int unsigned GW        = (GRADES > 2) ? $clog2(GRADES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_flag,
  input  logic [1:0]       key_value,
  input  logic             key_hold,
  output logic [CSW-1:0]   ch_sel,
  output logic [CH*TW-1:0] threshold,
  output logic [GW-1:0]    grade_cur,
  output logic             upd
);

  localparam int unsigned RMAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int unsigned CW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int unsigned SW   = TW + GW;
  localparam logic [GW-1:0] GMAX = GW'(GRADES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic [CSW-1:0]      ch_q, ch_d;
  logic [GW-1:0]       grade_q [CH];
  logic [CH*TW-1:0]    threshold_q;
  logic                upd_q, upd_d;

  logic                flag_ud, flag_nc, tick;
  logic                step_en, step_up;
  logic [GW-1:0]       g_cur, g_nxt;

  // Threshold for a grade, computed wide and clamped to the output range.
  function automatic logic [TW-1:0] thr_of(input logic [GW-1:0] g);
    logic [SW-1:0] s;
    s = SW'(THR_BASE) + SW'(g) * SW'(THR_STEP);
    if (s > SW'({TW{1'b1}})) thr_of = '1;
    else                     thr_of = s[TW-1:0];
  endfunction

  assign flag_ud = key_flag && ((key_value == 2'b01) || (key_value == 2'b10));
  assign flag_nc = key_flag && (key_value == 2'b11);
  assign g_cur   = grade_q[ch_q];

  // Auto-repeat FSM, channel select and step arbitration (key_flag beats tick).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ch_d    = ch_q;
    tick    = 1'b0;
    step_en = 1'b0;
    step_up = dir_q;

    case (state_q)
      DELAY: begin
        if (!key_hold) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(REP_DLY - 1)) begin
          tick    = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPEAT: begin
        if (!key_hold) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(REP_PER - 1)) begin
          tick  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    if (flag_ud) begin
      step_en = 1'b1;
      step_up = key_value[1];
      dir_d   = key_value[1];
      cnt_d   = '0;
      state_d = DELAY;
    end else if (flag_nc) begin
      ch_d    = (ch_q == CSW'(CH - 1)) ? '0 : ch_q + CSW'(1);
      cnt_d   = '0;
      state_d = IDLE;
    end else if (tick) begin
      step_en = 1'b1;
    end
  end

  // Next grade of the selected channel for the pending step.
  always_comb begin
    g_nxt = g_cur;
    if (step_up) begin
      if (g_cur == GMAX) begin
`ifdef THRESH_WRAP_EN
        g_nxt = '0;
`else
        g_nxt = g_cur;
`endif
      end else begin
        g_nxt = g_cur + GW'(1);
      end
    end else begin
      if (g_cur == '0) begin
`ifdef THRESH_WRAP_EN
        g_nxt = GMAX;
`else
        g_nxt = g_cur;
`endif
      end else begin
        g_nxt = g_cur - GW'(1);
      end
    end
    upd_d = step_en && (g_nxt != g_cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      ch_q        <= '0;
      upd_q       <= 1'b0;
      threshold_q <= {CH{thr_of(GW'(GRADE_INIT))}};
      for (int unsigned n = 0; n < CH; n++) grade_q[n] <= GW'(GRADE_INIT);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ch_q    <= ch_d;
      upd_q   <= upd_d;
      if (step_en) grade_q[ch_q] <= g_nxt;
      for (int unsigned n = 0; n < CH; n++) threshold_q[n*TW +: TW] <= thr_of(grade_q[n]);
    end
  end

  assign ch_sel    = ch_q;
  assign threshold = threshold_q;
  assign grade_cur = g_cur;
  assign upd       = upd_q;

endmodule

// File: tb/tb_threshold_adj_mc.sv
// Self-checking bench for threshold_adj_mc: directed scenarios plus random key traffic
// compared cycle by cycle against a behavioural model.
module tb_threshold_adj_mc;

  localparam int NCH     = 4;
  localparam int NGR     = 16;
  localparam int G_INIT  = 9;
  localparam int REP_DLY = 8;
  localparam int REP_PER = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_flag = 1'b0;
  logic [1:0]  key_value = 2'b00;
  logic        key_hold = 1'b0;
  logic [1:0]  ch_sel;
  logic [31:0] threshold;
  logic [3:0]  grade_cur;
  logic        upd;

  always #5 clk = ~clk;

  threshold_adj_mc #(.REP_DLY(REP_DLY), .REP_PER(REP_PER)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .key_flag  (key_flag),
    .key_value (key_value),
    .key_hold  (key_hold),
    .ch_sel    (ch_sel),
    .threshold (threshold),
    .grade_cur (grade_cur),
    .upd       (upd)
  );

  int m_grade [NCH];
  int m_thr   [NCH];
  int m_ch;
  bit m_upd;
  bit m_alive;
  bit m_dir;
  int m_age;

  int n_vec = 0;
  int n_mis = 0;
  int upd_seen = 0;

  function automatic int thr(input int g);
    int t;
    t = 10 + g * 10;
    return (t > 255) ? 255 : t;
  endfunction

  task automatic do_step(input bit up);
    int g, ng;
    g  = m_grade[m_ch];
    ng = up ? g + 1 : g - 1;
`ifdef THRESH_WRAP_EN
    ng = (ng + NGR) % NGR;
`else
    if (ng < 0) ng = 0;
    if (ng > NGR - 1) ng = NGR - 1;
`endif
    m_upd = (ng != g);
    m_grade[m_ch] = ng;
  endtask

  // Model: a held key ticks at ages REP_DLY, REP_DLY+REP_PER, ... after the press.
  task automatic model_edge();
    bit tick, ud, nc;
    tick = 1'b0;
    ud = key_flag && (key_value == 2'd1 || key_value == 2'd2);
    nc = key_flag && (key_value == 2'd3);
    if (rst) begin
      for (int n = 0; n < NCH; n++) begin
        m_grade[n] = G_INIT;
        m_thr[n]   = thr(G_INIT);
      end
      m_ch = 0; m_upd = 1'b0; m_alive = 1'b0; m_age = 0;
      return;
    end
    for (int n = 0; n < NCH; n++) m_thr[n] = thr(m_grade[n]);
    m_upd = 1'b0;
    if (m_alive) begin
      m_age++;
      if (!key_hold) m_alive = 1'b0;
      else tick = (m_age == REP_DLY) ||
                  (m_age > REP_DLY && ((m_age - REP_DLY) % REP_PER) == 0);
    end
    if (ud) begin
      do_step(key_value[1]);
      m_dir = key_value[1];
      m_alive = 1'b1;
      m_age = 0;
    end else if (nc) begin
      m_ch = (m_ch + 1) % NCH;
      m_alive = 1'b0;
    end else if (tick) begin
      do_step(m_dir);
    end
  endtask

  task automatic check();
    logic [31:0] e;
    for (int n = 0; n < NCH; n++) e[n*8 +: 8] = 8'(m_thr[n]);
    n_vec++;
    if (int'(ch_sel) != m_ch) begin
      n_mis++; $display("FAIL ch_sel t=%0t got %0d exp %0d", $time, ch_sel, m_ch);
    end
    if (int'(grade_cur) != m_grade[m_ch]) begin
      n_mis++; $display("FAIL grade_cur t=%0t got %0d exp %0d", $time, grade_cur, m_grade[m_ch]);
    end
    if (upd !== m_upd) begin
      n_mis++; $display("FAIL upd t=%0t got %b exp %b", $time, upd, m_upd);
    end
    if (threshold !== e) begin
      n_mis++; $display("FAIL threshold t=%0t got %h exp %h", $time, threshold, e);
    end
    if (upd === 1'b1) upd_seen++;
  endtask

  task automatic pin(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit f, input logic [1:0] v, input bit h, input bit r);
    rst = r; key_flag = f; key_value = v; key_hold = h;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check();
  endtask

  initial begin
    bit h;
    // Reset and idle
    cyc(0, 2'd0, 0, 1);
    cyc(0, 2'd0, 0, 1);
    repeat (3) cyc(0, 2'd0, 0, 0);
    pin("rst_thr", int'(threshold), 32'h64646464);
    pin("rst_ch", int'(ch_sel), 0);
    pin("rst_grade", int'(grade_cur), 9);
    pin("rst_upd", int'(upd), 0);

    // Single up press on channel 0
    upd_seen = 0;
    cyc(1, 2'd2, 0, 0);
    pin("up_grade", int'(grade_cur), 10);
    cyc(0, 2'd0, 0, 0);
    pin("up_thr0", int'(threshold[7:0]), 110);
    pin("up_thr_rest", int'(threshold[31:8]), 24'h646464);
    repeat (2) cyc(0, 2'd0, 0, 0);
    pin("up_upd_cnt", upd_seen, 1);

    // Channel walk then down to the floor of channel 1
    for (int i = 0; i < 5; i++) begin
      cyc(1, 2'd3, 0, 0);
      pin("ch_walk", int'(ch_sel), (i + 1) % 4);
    end
    upd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 2'd1, 0, 0);
      cyc(0, 2'd0, 0, 0);
    end
    cyc(0, 2'd0, 0, 0);
    pin("down_thr1", int'(threshold[15:8]), 10);
    pin("down_grade", int'(grade_cur), 0);
    pin("down_upd_cnt", upd_seen, 9);

    // Auto-repeat: held 20 cycles gives steps at 0, 8, 12, 16
    upd_seen = 0;
    cyc(1, 2'd2, 1, 0);
    repeat (19) cyc(0, 2'd0, 1, 0);
    repeat (10) cyc(0, 2'd0, 0, 0);
    pin("rep_upd_cnt", upd_seen, 4);
    pin("rep_grade", int'(grade_cur), 4);

    // Top boundary on channel 2
    cyc(1, 2'd3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 2'd2, 0, 0);
      cyc(0, 2'd0, 0, 0);
    end
    pin("pre_sat_grade", int'(grade_cur), 14);
    upd_seen = 0;
    cyc(1, 2'd2, 1, 0);
    repeat (9) cyc(0, 2'd0, 1, 0);
    repeat (3) cyc(0, 2'd0, 0, 0);
`ifdef THRESH_WRAP_EN
    pin("sat_grade", int'(grade_cur), 0);
    pin("sat_thr2", int'(threshold[23:16]), 10);
    pin("sat_upd_cnt", upd_seen, 2);
`else
    pin("sat_grade", int'(grade_cur), 15);
    pin("sat_thr2", int'(threshold[23:16]), 160);
    pin("sat_upd_cnt", upd_seen, 1);
`endif

    // Reset in the middle of repeat on channel 0
    cyc(1, 2'd3, 0, 0);
    cyc(1, 2'd3, 0, 0);
    cyc(1, 2'd2, 1, 0);
    repeat (13) cyc(0, 2'd0, 1, 0);
    pin("prerst_grade", int'(grade_cur), 13);
    cyc(0, 2'd0, 1, 1);
    pin("rst_rep_grade", int'(grade_cur), 9);
    pin("rst_rep_ch", int'(ch_sel), 0);
    pin("rst_rep_thr0", int'(threshold[7:0]), 100);
    upd_seen = 0;
    repeat (12) cyc(0, 2'd0, 1, 0);
    pin("rst_rep_no_tick", upd_seen, 0);
    pin("rst_rep_grade2", int'(grade_cur), 9);

    // Random key traffic
    h = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) h = ~h;
      cyc(($urandom_range(7) == 0), 2'($urandom_range(3)), h, ($urandom_range(499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
